dmac_ahb_master: RTL and testbench
==================================

// Module: dmac_ahb_master
// PURPOSE
//  AHB-Lite initiator (master) side of the DMA controller. Executes one
//  programmed channel transfer of 32-bit words: single-beat read from source,
//  then single-beat write to destination, repeated `size` times.
//  Sits between the channel arbiter (which supplies sour/dest/size/target from
//  the dmac register block) and the system AHB-Lite bus.
// PARAMETERS
//  SIZE_W   10  width of word-count field (matches ch_x_size)
//  ADDR_INC 4   byte increment per word on the incrementing side
// PORTS
//  HCLK       in   1   bus clock; all logic on rising edge
//  HRESETn    in   1   reset, synchronous, active-low
//  start      in   1   one-cycle request; accepted only while busy=0
//  src_addr   in   32  source byte address (ch_x_sour)
//  dst_addr   in   32  destination byte address (ch_x_dest)
//  size       in   10  number of words to move
//  target     in   1   0: mem->periph (src incr, dst fixed); 1: periph->mem (src fixed, dst incr)
//  abort      in   1   level; stop after current beat completes
//  busy       out  1   high from cycle after accepted start until done cycle inclusive
//  done       out  1   one-cycle pulse at end of transfer (normal, abort or error)
//  err        out  1   valid with done: 1 = HRESP error or abort terminated the run
//  words_done out  10  words fully written in current/last run
//  HADDR      out  32  AHB address, bits[1:0] forced 2'b00
//  HTRANS     out  2   IDLE 2'b00 / NONSEQ 2'b10 only
//  HWRITE     out  1   1 in write address phase
//  HSIZE      out  3   constant 3'b010 (word)
//  HBURST     out  3   constant 3'b000 (SINGLE)
//  HWDATA     out  32  write data, driven in write data phase
//  HRDATA     in   32  read data
//  HREADY     in   1   transfer/phase complete
//  HRESP      in   1   1 = ERROR
// BEHAVIOUR
//  - Reset (HRESETn=0 at edge): state=IDLE; busy,done,err=0; words_done=0;
//    HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0; data buffer=0. Reset mid-run
//    drops the run immediately; no done pulse.
//  - FSM: IDLE, RD_A, RD_D, WR_A, WR_D, FIN. Bus outputs decoded from registered
//    state/pointers only; no comb path from HREADY/HRESP to outputs.
//  - IDLE: start=1 latches src/dst/size/target, clears words_done -> RD_A
//    (size=0 -> FIN). start while busy is ignored.
//  - RD_A: HTRANS=NONSEQ, HADDR=src_ptr, HWRITE=0; held until HREADY=1 -> RD_D.
//  - RD_D: HTRANS=IDLE; HREADY=1 & HRESP=0: capture HRDATA into buffer -> WR_A.
//  - WR_A: HTRANS=NONSEQ, HADDR=dst_ptr, HWRITE=1; HREADY=1 -> WR_D.
//  - WR_D: HTRANS=IDLE, HWDATA=buffer (stable whole phase); HREADY=1 & HRESP=0:
//    words_done+1, remaining-1, advance incrementing pointer by ADDR_INC;
//    remaining reaches 0 or abort=1 -> FIN, else -> RD_A.
//  - HRESP=1 seen in any data phase (either cycle of 2-cycle ERROR) -> FIN with
//    err=1; no further NONSEQ issued; failed word not counted.
//  - abort: sampled only at beat end (WR_D complete) -> FIN, err=1 if words
//    remained. An in-flight AHB phase is never abandoned.
//  - FIN: done=1, busy=1 for this one cycle -> IDLE. err held until next start.
//  - Latency, zero wait states: start at cycle 0, done at cycle 4*size+1; size=0:
//    done at cycle 1. Each HREADY-low cycle adds one cycle.
//  - Pointers wrap modulo 2^32; fixed-side pointer never changes during the run.
// STRUCTURE
//  - dmac_pkg: HTRANS_IDLE/HTRANS_NONSEQ, HSIZE_WORD, HBURST_SINGLE, FSM state
//    encodings, TARGET_M2P/TARGET_P2M.
//  - Single module; no sub-module. Pointer/count update lives in one always block.
// TESTING
//  - size=3, target=0, src=0x2000_0000, dst=0x4000_1000, zero wait -> reads at
//    0x..00/04/08, all writes to 0x4000_1000, done at cycle 13, err=0, words_done=3.
//  - size=2, target=1, src=0x4000_2000, dst=0x2000_0100 -> src fixed, writes to
//    0x2000_0100/0104, HWDATA equals prior HRDATA.
//  - HREADY low 2 cycles in each phase of size=1 -> HADDR/HTRANS/HWDATA held
//    stable, done at cycle 1+4+8=13.
//  - ERROR on 2nd read of size=4 -> no 2nd write, done with err=1, words_done=1.
//  - abort asserted in RD_D of word 1 of size=5 -> word 1 written, done err=1,
//    words_done=1; size=0 start -> done cycle 1, no NONSEQ on bus.
//  - HRESETn=0 during WR_A -> next cycle HTRANS=IDLE, busy=0, no done pulse.

Source files
------------

// File: rtl/dmac_pkg.sv
// Shared constants for the DMA controller's AHB-Lite master: bus encodings,
// transfer direction codes and the master FSM state type.
package dmac_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic TARGET_M2P = 1'b0;
    localparam logic TARGET_P2M = 1'b1;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StRdA  = 3'd1,
        StRdD  = 3'd2,
        StWrA  = 3'd3,
        StWrD  = 3'd4,
        StFin  = 3'd5
    } ahb_state_e;

endpackage

// File: rtl/dmac_ahb_master.sv
// AHB-Lite master for one DMA channel run: single-beat read then single-beat
// write per word, repeated size times, with abort and error termination.
module dmac_ahb_master
    import dmac_pkg::*;
#(
    parameter int unsigned SIZE_W   = 10,
    parameter int unsigned ADDR_INC = 4
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              start,
    input  logic [31:0]       src_addr,
    input  logic [31:0]       dst_addr,
    input  logic [SIZE_W-1:0] size,
    input  logic              target,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [SIZE_W-1:0] words_done,
    output logic [31:0]       HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [31:0]       HWDATA,
    input  logic [31:0]       HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);

    ahb_state_e        state_q, state_d;
    logic [31:0]       src_ptr_q;
    logic [31:0]       dst_ptr_q;
    logic [SIZE_W-1:0] remaining_q;
    logic [SIZE_W-1:0] words_done_q;
    logic              target_q;
    logic [31:0]       buffer_q;
    logic              err_q;
    logic              last_word;

    assign last_word = (remaining_q == SIZE_W'(1));

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and bus outputs; outputs depend only on registered state.
    always_comb begin
        state_d = state_q;
        HTRANS  = HTRANS_IDLE;
        HADDR   = 32'h0;
        HWRITE  = 1'b0;
        HWDATA  = 32'h0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (size == '0) ? StFin : StRdA;
                end
            end
            StRdA: begin
                HTRANS = HTRANS_NONSEQ;
                HADDR  = src_ptr_q & ~32'h3;
                if (HREADY) begin
                    state_d = StRdD;
                end
            end
            StRdD: begin
                if (HRESP) begin
                    state_d = StFin;
                end else if (HREADY) begin
                    state_d = StWrA;
                end
            end
            StWrA: begin
                HTRANS = HTRANS_NONSEQ;
                HADDR  = dst_ptr_q & ~32'h3;
                HWRITE = 1'b1;
                if (HREADY) begin
                    state_d = StWrD;
                end
            end
            StWrD: begin
                HWDATA = buffer_q;
                if (HRESP) begin
                    state_d = StFin;
                end else if (HREADY) begin
                    state_d = (last_word || abort) ? StFin : StRdA;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Pointers, counters, data buffer and the sticky error flag.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            src_ptr_q    <= 32'h0;
            dst_ptr_q    <= 32'h0;
            remaining_q  <= '0;
            words_done_q <= '0;
            target_q     <= TARGET_M2P;
            buffer_q     <= 32'h0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        src_ptr_q    <= src_addr;
                        dst_ptr_q    <= dst_addr;
                        remaining_q  <= size;
                        words_done_q <= '0;
                        target_q     <= target;
                        err_q        <= 1'b0;
                    end
                end
                StRdD: begin
                    if (HRESP) begin
                        err_q <= 1'b1;
                    end else if (HREADY) begin
                        buffer_q <= HRDATA;
                    end
                end
                StWrD: begin
                    if (HRESP) begin
                        err_q <= 1'b1;
                    end else if (HREADY) begin
                        words_done_q <= words_done_q + SIZE_W'(1);
                        remaining_q  <= remaining_q - SIZE_W'(1);
                        if (target_q == TARGET_P2M) begin
                            dst_ptr_q <= dst_ptr_q + 32'(ADDR_INC);
                        end else begin
                            src_ptr_q <= src_ptr_q + 32'(ADDR_INC);
                        end
                        if (abort && !last_word) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StFin);
    assign err        = err_q;
    assign words_done = words_done_q;
    assign HSIZE      = HSIZE_WORD;
    assign HBURST     = HBURST_SINGLE;

endmodule

// File: tb/tb_dmac_ahb_master.sv
// Scoreboard bench for dmac_ahb_master: a slave model answers the bus, expected
// address phases and done events are queued, and a monitor checks them as seen.
module tb_dmac_ahb_master;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
    } beat_t;

    typedef struct packed {
        int          cyc;
        logic        err;
        logic [9:0]  wd;
    } done_t;

    logic        HCLK, HRESETn;
    logic        start, target, abort;
    logic [31:0] src_addr, dst_addr;
    logic [9:0]  size;
    logic        busy, done, err;
    logic [9:0]  words_done;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;

    int vec = 0;
    int miscompares = 0;
    int cyc = 0;
    int start_cyc = 0;

    // slave model controls
    int ws = 0;
    int err_at = 0;
    int rd_idx = 0;

    beat_t beat_q[$];
    done_t done_q[$];

    dmac_ahb_master #(.SIZE_W(10), .ADDR_INC(4)) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .size       (size),
        .target     (target),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .words_done (words_done),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HWRITE     (HWRITE),
        .HSIZE      (HSIZE),
        .HBURST     (HBURST),
        .HWDATA     (HWDATA),
        .HRDATA     (HRDATA),
        .HREADY     (HREADY),
        .HRESP      (HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_beat(input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
        beat_t b;
        b.addr = addr;
        b.wr = wr;
        b.wdata = wdata;
        beat_q.push_back(b);
    endtask

    task automatic push_done(input int c, input logic e, input logic [9:0] wd);
        done_t d;
        d.cyc = c;
        d.err = e;
        d.wd = wd;
        done_q.push_back(d);
    endtask

    task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [9:0] n,
                       input logic t);
        @(posedge HCLK);
        #2;
        src_addr = s;
        dst_addr = d;
        size = n;
        target = t;
        start = 1'b1;
        start_cyc = cyc;
        rd_idx = 0;
        @(posedge HCLK);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge HCLK);
            n++;
        end while (!done && n < 200);
        if (!done) begin
            vec++;
            miscompares++;
            $display("FAIL %s_timeout: got no done expected done within 200 cycles", name);
        end
        @(negedge HCLK);
        chk({name, "_queues_empty"}, 32'(beat_q.size() + done_q.size()), 32'd0);
    endtask

    // Slave: decides HREADY/HRESP/HRDATA for the current cycle just after the edge.
    initial begin : slave
        int dph;
        int cnt;
        bit errsec;
        logic [31:0] rd_addr;
        dph = 0;
        cnt = 0;
        errsec = 0;
        rd_addr = 32'h0;
        HREADY = 1'b1;
        HRESP = 1'b0;
        HRDATA = 32'h0;
        forever begin
            @(posedge HCLK);
            #1;
            if (!HRESETn) begin
                dph = 0;
                cnt = 0;
                errsec = 0;
                HREADY = 1'b1;
                HRESP = 1'b0;
            end else if (errsec) begin
                HREADY = 1'b1;
                HRESP = 1'b1;
                errsec = 0;
                dph = 0;
            end else if (dph != 0) begin
                if (dph == 1 && rd_idx == err_at) begin
                    HREADY = 1'b0;
                    HRESP = 1'b1;
                    errsec = 1;
                end else if (cnt < ws) begin
                    HREADY = 1'b0;
                    HRESP = 1'b0;
                    cnt++;
                end else begin
                    HREADY = 1'b1;
                    HRESP = 1'b0;
                    cnt = 0;
                    if (dph == 1) HRDATA = ~rd_addr;
                    dph = 0;
                end
            end else if (HTRANS == 2'b10) begin
                HRESP = 1'b0;
                if (cnt < ws) begin
                    HREADY = 1'b0;
                    cnt++;
                end else begin
                    HREADY = 1'b1;
                    cnt = 0;
                    dph = HWRITE ? 2 : 1;
                    if (!HWRITE) begin
                        rd_addr = HADDR;
                        rd_idx++;
                    end
                end
            end else begin
                HREADY = 1'b1;
                HRESP = 1'b0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT completes a phase or signals done.
    initial begin : monitor
        bit wr_pend;
        bit hold_v;
        logic [31:0] exp_wdata;
        logic [31:0] hold_addr;
        beat_t b;
        done_t d;
        wr_pend = 0;
        hold_v = 0;
        exp_wdata = 32'h0;
        hold_addr = 32'h0;
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                wr_pend = 0;
                hold_v = 0;
            end else begin
                if (wr_pend) begin
                    chk("hwdata", HWDATA, exp_wdata);
                    if (HREADY) wr_pend = 0;
                end
                if (hold_v) begin
                    chk("htrans_hold", 32'(HTRANS), 32'h2);
                    chk("haddr_hold", HADDR, hold_addr);
                end
                hold_v = (HTRANS == 2'b10) && !HREADY;
                hold_addr = HADDR;
                if (HTRANS == 2'b10 && HREADY) begin
                    if (beat_q.size() == 0) begin
                        vec++;
                        miscompares++;
                        $display("FAIL unexpected_nonseq: got addr %h expected no transfer", HADDR);
                    end else begin
                        b = beat_q.pop_front();
                        chk("haddr", HADDR, b.addr);
                        chk("hwrite", 32'(HWRITE), 32'(b.wr));
                        if (b.wr) begin
                            wr_pend = 1;
                            exp_wdata = b.wdata;
                        end
                    end
                end
                if (done) begin
                    if (done_q.size() == 0) begin
                        vec++;
                        miscompares++;
                        $display("FAIL unexpected_done: got done=1 expected done=0");
                    end else begin
                        d = done_q.pop_front();
                        chk("done_cycle", 32'(cyc - start_cyc), 32'(d.cyc));
                        chk("done_err", 32'(err), 32'(d.err));
                        chk("words_done", 32'(words_done), 32'(d.wd));
                        chk("busy_at_done", 32'(busy), 32'd1);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100us");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        HRESETn = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        target = 1'b0;
        size = 10'd0;
        src_addr = 32'h0;
        dst_addr = 32'h0;
        repeat (3) @(posedge HCLK);
        #2;
        HRESETn = 1'b1;
        @(negedge HCLK);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_words_done", 32'(words_done), 32'd0);
        chk("rst_htrans", 32'(HTRANS), 32'd0);
        chk("rst_haddr", HADDR, 32'd0);
        chk("rst_hwrite", 32'(HWRITE), 32'd0);
        chk("rst_hwdata", HWDATA, 32'd0);
        chk("hsize", 32'(HSIZE), 32'd2);
        chk("hburst", 32'(HBURST), 32'd0);

        // mem->periph, 3 words, zero wait; a start mid-run must be ignored
        push_beat(32'h2000_0000, 1'b0, 32'h0);
        push_beat(32'h4000_1000, 1'b1, 32'hDFFF_FFFF);
        push_beat(32'h2000_0004, 1'b0, 32'h0);
        push_beat(32'h4000_1000, 1'b1, 32'hDFFF_FFFB);
        push_beat(32'h2000_0008, 1'b0, 32'h0);
        push_beat(32'h4000_1000, 1'b1, 32'hDFFF_FFF7);
        push_done(13, 1'b0, 10'd3);
        run(32'h2000_0000, 32'h4000_1000, 10'd3, 1'b0);
        repeat (3) @(posedge HCLK);
        #2;
        src_addr = 32'hDEAD_0000;
        size = 10'd7;
        start = 1'b1;
        @(posedge HCLK);
        #2;
        start = 1'b0;
        wait_done("m2p");

        // periph->mem, 2 words: source fixed, destination increments
        push_beat(32'h4000_2000, 1'b0, 32'h0);
        push_beat(32'h2000_0100, 1'b1, 32'hBFFF_DFFF);
        push_beat(32'h4000_2000, 1'b0, 32'h0);
        push_beat(32'h2000_0104, 1'b1, 32'hBFFF_DFFF);
        push_done(9, 1'b0, 10'd2);
        run(32'h4000_2000, 32'h2000_0100, 10'd2, 1'b1);
        wait_done("p2m");

        // two wait states in every phase
        ws = 2;
        push_beat(32'h3000_0010, 1'b0, 32'h0);
        push_beat(32'h6000_0000, 1'b1, 32'hCFFF_FFEF);
        push_done(13, 1'b0, 10'd1);
        run(32'h3000_0010, 32'h6000_0000, 10'd1, 1'b0);
        wait_done("waits");
        ws = 0;

        // ERROR response on the second read
        err_at = 2;
        push_beat(32'h1000_0000, 1'b0, 32'h0);
        push_beat(32'h5000_0000, 1'b1, 32'hEFFF_FFFF);
        push_beat(32'h1000_0004, 1'b0, 32'h0);
        push_done(7, 1'b1, 10'd1);
        run(32'h1000_0000, 32'h5000_0000, 10'd4, 1'b0);
        wait_done("error");
        err_at = 0;
        chk("err_held", 32'(err), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);

        // abort raised during the first read data phase of a 5-word run
        push_beat(32'h2100_0000, 1'b0, 32'h0);
        push_beat(32'h4100_0000, 1'b1, 32'hDEFF_FFFF);
        push_done(5, 1'b1, 10'd1);
        run(32'h2100_0000, 32'h4100_0000, 10'd5, 1'b0);
        @(posedge HCLK);
        #2;
        abort = 1'b1;
        wait_done("abort");
        abort = 1'b0;

        // size 0: immediate done, no bus traffic
        push_done(1, 1'b0, 10'd0);
        run(32'h7000_0000, 32'h7100_0000, 10'd0, 1'b0);
        wait_done("size0");
        chk("size0_clears_err", 32'(err), 32'd0);

        // reset asserted while the first write address phase is on the bus
        push_beat(32'h2200_0000, 1'b0, 32'h0);
        run(32'h2200_0000, 32'h4200_0000, 10'd2, 1'b0);
        repeat (2) @(posedge HCLK);
        #2;
        chk("in_wr_a", {29'h0, HTRANS, HWRITE}, 32'h5);
        HRESETn = 1'b0;
        @(posedge HCLK);
        #2;
        HRESETn = 1'b1;
        @(negedge HCLK);
        chk("rst_mid_htrans", 32'(HTRANS), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        repeat (10) @(negedge HCLK);
        chk("rst_mid_queues_empty", 32'(beat_q.size() + done_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miscompares);
        $finish;
    end

endmodule
